cordic_iter: RTL and testbench
==============================

# cordic_iter

Parametrised, iterative, single-stage-reuse CORDIC engine for the baby_cordic peripheral. It replaces the fixed 19-bit, cos-or-sin-only unit. It returns cos and sin together and uses a valid/ready handshake on both sides. An optional vectoring mode returns magnitude and angle. One micro-rotation is performed per enabled clock.

## Interface
Parameters:
- W, 19: signed data width; Q(W-FRAC).FRAC two's complement.
- FRAC, 16: fractional bits. Requires FRAC <= W-3, so ±PI is representable.
- STAGES, 12: micro-rotations per operation; range 4..16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  advances the FSM and datapath only when high
- in_valid  in  1  request present
- in_ready  out  1  engine can accept; high only in IDLE
- mode  in  1  0 = rotation, 1 = vectoring (ignored, treated as 0, without CORDIC_VECTOR_EN)
- a_in  in  W  rotation: theta; vectoring: x
- b_in  in  W  vectoring: y; ignored in rotation
- out_valid  out  1  result held stable
- out_ready  in  1  consumer accepts result
- res_a  out  W  rotation: cos; vectoring: magnitude (uncompensated)
- res_b  out  W  rotation: sin; vectoring: angle

## Operation
- States: IDLE, BUSY, HOLD. Reset puts the FSM in IDLE and clears the counter, x/y/z, res_a, res_b and out_valid to 0. in_ready is 1 after reset.
- IDLE: on clk_en & in_valid, latch the operands and go to BUSY with count = 0.
- BUSY: one iteration per clk_en cycle. After iteration STAGES-1, write the results, set out_valid and go to HOLD.
- HOLD: on clk_en & out_ready, clear out_valid and go to IDLE.
- Internal x/y/z are W+2 bits wide (guard bits).
- Shifts are arithmetic right shifts with truncation.
- Results are saturated to W bits on write-out.
- The atan table holds round(atan(2^-i)·2^FRAC) for i = 0..STAGES-1. It is built at elaboration from a 32-fraction-bit constant table, shifted right with round-half-up.
- Rotation mode:
  - theta is first saturated to [-PI, PI], where PI = round(π·2^FRAC).
  - If theta > PI/2: z0 = PI-theta and cos is negated.
  - If theta < -PI/2: z0 = -PI-theta and cos is negated.
  - Otherwise z0 = theta.
  - sin is never negated.
  - x0 = K = round(0.6072529350·2^FRAC), y0 = 0.
  - d = +1 if z >= 0, else -1.
  - Each iteration: x' = x - d·(y>>>i), y' = y + d·(x>>>i), z' = z - d·atan_i.
  - res_a = ±x_n, res_b = y_n.
- Vectoring mode:
  - If x < 0, pre-rotate: x0 = -x, y0 = -y, z0 = (y >= 0) ? PI : -PI.
  - Otherwise z0 = 0.
  - d = +1 if y < 0, else -1.
  - Same update equations as rotation mode.
  - res_a = x_n (gain ≈1.64676, not compensated), res_b = z_n.
  - x = y = 0 yields res_a = 0, res_b = 0.
- mode is sampled only on acceptance. a_in and b_in are ignored outside acceptance.

## Timing
- Acceptance edge is T0. out_valid rises at edge T0+STAGES, counted in clk_en-high cycles (default 12).
- Earliest next acceptance is one clk_en cycle after the out_ready handshake. Sustained throughput is one result per STAGES+2 enabled cycles.
- clk_en low freezes all state and outputs, including out_valid and in_ready.
- res_a and res_b are stable from out_valid rise until the accepting edge. They keep their last values afterwards.
- in_valid asserted during BUSY or HOLD is not accepted; the requester must hold it.
- rst wins over everything, including mid-BUSY and HOLD. The operation in flight is dropped with no out_valid pulse, and in_ready is 1 on the cycle after the reset edge.

## Configuration
- CORDIC_VECTOR_EN defined: vectoring mode, pre-rotation and the b_in path are compiled in.
- CORDIC_VECTOR_EN undefined: rotation only. mode and b_in are unused, with no logic behind them. Rotation results are identical to the macro-defined build.

## Test plan
Defaults W=19, FRAC=16, STAGES=12; tolerance ±16 LSB.
- theta = 0x00000 -> res_a ≈ 0x10000, res_b ≈ 0x00000. out_valid rises exactly 12 enabled cycles after acceptance.
- theta = 0x1921F (π/2) -> res_a ≈ 0, res_b ≈ 0x10000. theta = 0x3243F (π) -> res_a ≈ -0x10000 (0x70000), res_b ≈ 0.
- theta = -0x0C910 (-π/4) -> res_a ≈ 0x0B505, res_b ≈ -0x0B505. theta = 0x3FFFF (over range) -> saturates to π, same result as π.
- Backpressure: hold out_ready low for 5 cycles after out_valid. Results stay constant and in_ready stays 0. A second request with in_valid held is accepted exactly one cycle after the handshake.
- Toggle clk_en 50% during BUSY -> identical results, with latency doubled in clk cycles. Assert rst at count = 6 -> out_valid never rises and in_ready = 1 on the next cycle.
- With CORDIC_VECTOR_EN:
  - mode=1, x = y = 0x08000 -> res_a ≈ 0x12A18, res_b ≈ 0x0C910.
  - x = -0x08000, y = 0x08000 -> res_b ≈ 0x25B2F (3π/4).

Source files
------------

// File: rtl/cordic_iter.sv
// Iterative CORDIC, one micro-rotation per enabled clock: rotation -> cos/sin, optional vectoring -> magnitude/angle (CORDIC_VECTOR_EN).
// Latency: STAGES clk_en-high cycles from the acceptance edge to out_valid.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE; clk_en low freezes everything.
module cordic_iter #(
    parameter int W      = 19,
    parameter int FRAC   = 16,
    parameter int STAGES = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_a,
    output logic [W-1:0] res_b
);

    // Two guard bits keep the un-normalised vectoring gain and the +-PI pre-rotation in range.
    localparam int IW = W + 2;
    localparam int CW = $clog2(STAGES);

    // atan(2^-i) with 32 fraction bits.
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:       return 32'hC90FDAA2;
            1:       return 32'h76B19C16;
            2:       return 32'h3EB6EBF2;
            3:       return 32'h1FD5BA9B;
            4:       return 32'h0FFAADDC;
            5:       return 32'h07FF556F;
            6:       return 32'h03FFEAAB;
            7:       return 32'h01FFFD55;
            8:       return 32'h00FFFFAB;
            9:       return 32'h007FFFF5;
            10:      return 32'h003FFFFF;
            11:      return 32'h00200000;
            12:      return 32'h00100000;
            13:      return 32'h00080000;
            14:      return 32'h00040000;
            15:      return 32'h00020000;
            default: return 32'h00000000;
        endcase
    endfunction

    // Reduce a 32-fraction-bit constant to FRAC bits, round half up.
    function automatic logic signed [IW-1:0] round_q32(input logic [33:0] v);
        logic [34:0] t;
        t = {1'b0, v} + (35'd1 << (31 - FRAC));
        return IW'(t >> (32 - FRAC));
    endfunction

    localparam logic signed [IW-1:0] PI          = round_q32(34'h3243F6A88);
    localparam logic signed [IW-1:0] NEG_PI      = -PI;
    localparam logic signed [IW-1:0] HALF_PI     = PI >>> 1;
    localparam logic signed [IW-1:0] NEG_HALF_PI = -HALF_PI;
    localparam logic signed [IW-1:0] K_GAIN      = round_q32({2'b00, 32'h9B74EDA8});
    localparam logic signed [IW:0]   SAT_MAX     = {{(IW + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [IW:0]   SAT_MIN     = ~SAT_MAX;
    localparam logic [CW-1:0]        LAST        = CW'(STAGES - 1);

    function automatic logic [W-1:0] sat_w(input logic signed [IW:0] v);
        if (v > SAT_MAX)      return SAT_MAX[W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[W-1:0];
        else                  return v[W-1:0];
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic signed [IW-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic                   neg_q, neg_d;
    logic [W-1:0]           res_a_q, res_a_d, res_b_q, res_b_d;
    logic                   out_valid_q, out_valid_d;

    logic signed [IW-1:0]   atan_tab [STAGES];
    logic signed [IW-1:0]   a_ext, theta_sat, rot_z0;
    logic                   rot_neg;
    logic signed [IW-1:0]   x_sh, y_sh, atan_cur, x_it, y_it, z_it;
    logic signed [IW:0]     x_ext, y_ext, z_ext;
    logic                   d_pos;
    logic                   vec_run;
    logic [W-1:0]           res_a_w, res_b_w;

    for (genvar g = 0; g < STAGES; g++) begin : g_atan
        localparam logic signed [IW-1:0] ATAN_G = round_q32({2'b00, atan32(g)});
        assign atan_tab[g] = ATAN_G;
    end

    assign a_ext = {{2{a_in[W-1]}}, a_in};

`ifdef CORDIC_VECTOR_EN
    logic                   vec_q, vec_d, zero_q, zero_d;
    logic signed [IW-1:0]   b_ext, vec_x0, vec_y0, vec_z0;
    logic                   vec_zero;

    assign b_ext   = {{2{b_in[W-1]}}, b_in};
    assign vec_run = vec_q;

    // Vectoring start point: fold the left half-plane over by +-PI so the iterations converge.
    always_comb begin
        vec_x0   = a_ext;
        vec_y0   = b_ext;
        vec_z0   = '0;
        vec_zero = (a_in == '0) && (b_in == '0);
        if (a_ext[IW-1]) begin
            vec_x0 = -a_ext;
            vec_y0 = -b_ext;
            vec_z0 = b_ext[IW-1] ? NEG_PI : PI;
        end
    end
`else
    logic unused_vec;
    assign unused_vec = ^{mode, b_in};
    assign vec_run    = 1'b0;
`endif

    // Rotation start point: clamp theta to +-PI, fold outer quadrants into +-PI/2 and remember to flip cos.
    always_comb begin
        theta_sat = a_ext;
        if (a_ext > PI)          theta_sat = PI;
        else if (a_ext < NEG_PI) theta_sat = NEG_PI;
        rot_z0  = theta_sat;
        rot_neg = 1'b0;
        if (theta_sat > HALF_PI) begin
            rot_z0  = PI - theta_sat;
            rot_neg = 1'b1;
        end else if (theta_sat < NEG_HALF_PI) begin
            rot_z0  = NEG_PI - theta_sat;
            rot_neg = 1'b1;
        end
    end

    // One micro-rotation; direction from z (rotation) or from the sign of y (vectoring).
    always_comb begin
        x_sh     = x_q >>> count_q;
        y_sh     = y_q >>> count_q;
        atan_cur = atan_tab[count_q];
        d_pos    = vec_run ? y_q[IW-1] : ~z_q[IW-1];
        x_it     = d_pos ? (x_q - y_sh) : (x_q + y_sh);
        y_it     = d_pos ? (y_q + x_sh) : (y_q - x_sh);
        z_it     = d_pos ? (z_q - atan_cur) : (z_q + atan_cur);
    end

    assign x_ext = {x_it[IW-1], x_it};
    assign y_ext = {y_it[IW-1], y_it};
    assign z_ext = {z_it[IW-1], z_it};

    // Saturated results taken from the final iteration's outputs.
    always_comb begin
        res_a_w = sat_w(neg_q ? -x_ext : x_ext);
        res_b_w = sat_w(vec_run ? z_ext : y_ext);
`ifdef CORDIC_VECTOR_EN
        if (vec_run && zero_q) begin
            res_a_w = '0;
            res_b_w = '0;
        end
`endif
    end

    // FSM next state and datapath load/iterate/write-out; nothing moves without clk_en.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        neg_d       = neg_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        out_valid_d = out_valid_q;
`ifdef CORDIC_VECTOR_EN
        vec_d       = vec_q;
        zero_d      = zero_q;
`endif
        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = S_BUSY;
                        count_d = '0;
                        x_d     = K_GAIN;
                        y_d     = '0;
                        z_d     = rot_z0;
                        neg_d   = rot_neg;
`ifdef CORDIC_VECTOR_EN
                        vec_d   = mode;
                        zero_d  = mode && vec_zero;
                        if (mode) begin
                            x_d   = vec_x0;
                            y_d   = vec_y0;
                            z_d   = vec_z0;
                            neg_d = 1'b0;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    x_d     = x_it;
                    y_d     = y_it;
                    z_d     = z_it;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        count_d     = '0;
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        res_a_d     = res_a_w;
                        res_b_d     = res_b_w;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register; reset drops any operation in flight regardless of clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            neg_q       <= 1'b0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef CORDIC_VECTOR_EN
            vec_q       <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            neg_q       <= neg_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            out_valid_q <= out_valid_d;
`ifdef CORDIC_VECTOR_EN
            vec_q       <= vec_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Bench for cordic_iter (W=19, FRAC=16, STAGES=12): directed vectors with bit-exact expected results.
// Timing checks: 12-cycle latency, backpressure hold, clk_en freeze, reset mid-operation and in HOLD.
// Vectoring checks are compiled only with CORDIC_VECTOR_EN.
module tb_cordic_iter;
    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst, clk_en, in_valid, in_ready, mode, out_valid, out_ready;
    logic [W-1:0] a_in, b_in, res_a, res_b;

    int checks = 0;
    int errors = 0;

    // Hand-iterated results (K=0x9B75, 12 stages, truncating shifts).
    localparam logic [W-1:0] C0_A   = 19'h0FFFF;  // cos(0)    =  65535
    localparam logic [W-1:0] C0_B   = 19'h7FFF1;  // sin(0)    = -15
    localparam logic [W-1:0] CPI_A  = 19'h70001;  // cos(pi)   = -65535
    localparam logic [W-1:0] CP2_A  = 19'h7FFF1;  // cos(pi/2) = -15
    localparam logic [W-1:0] CP2_B  = 19'h0FFFF;  // sin(pi/2) =  65535
    localparam logic [W-1:0] CQ_A   = 19'h0B50E;  // cos(-pi/4) =  46350
    localparam logic [W-1:0] CQ_B   = 19'h74B01;  // sin(-pi/4) = -46335
    localparam logic [W-1:0] TH_P2  = 19'h1921F;
    localparam logic [W-1:0] TH_PI  = 19'h3243F;
    localparam logic [W-1:0] TH_NQ  = 19'h736F0;  // -0x0C910
    localparam logic [W-1:0] TH_NPI = 19'h4DBC1;  // -0x3243F

    always #5 clk = ~clk;

    cordic_iter #(.W(19), .FRAC(16), .STAGES(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_a     (res_a),
        .res_b     (res_b)
    );

    // Present one request from IDLE, then count edges until out_valid (bounded).
    task automatic do_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        mode = m; a_in = a; b_in = b; in_valid = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = 1'b0; a_in = '0; b_in = '0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (res_a !== '0) begin errors++; $display("FAIL reset_res_a got %h exp 0", res_a); end
        checks++; if (res_b !== '0) begin errors++; $display("FAIL reset_res_b got %h exp 0", res_b); end
    endtask

    task automatic test_zero();
        int lat;
        do_op(1'b0, '0, '0, lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL zero_latency got %0d exp 12", lat); end
        checks++; if (res_a !== C0_A) begin errors++; $display("FAIL zero_cos got %h exp %h", res_a, C0_A); end
        checks++; if (res_b !== C0_B) begin errors++; $display("FAIL zero_sin got %h exp %h", res_b, C0_B); end
        release_result();
    endtask

    task automatic test_quadrants();
        logic [W-1:0] th [6];
        logic [W-1:0] ea [6];
        logic [W-1:0] eb [6];
        int lat;
        th = '{TH_P2, TH_PI, TH_NQ, 19'h3FFFF, TH_NPI, 19'h40000};
        ea = '{CP2_A, CPI_A, CQ_A, CPI_A, CPI_A, CPI_A};
        eb = '{CP2_B, C0_B,  CQ_B, C0_B,  C0_B,  C0_B};
        for (int i = 0; i < 6; i++) begin
            do_op(1'b0, th[i], '0, lat);
            checks++; if (res_a !== ea[i]) begin errors++; $display("FAIL quad%0d_cos theta %h got %h exp %h", i, th[i], res_a, ea[i]); end
            checks++; if (res_b !== eb[i]) begin errors++; $display("FAIL quad%0d_sin theta %h got %h exp %h", i, th[i], res_b, eb[i]); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        mode = 1'b0; a_in = '0; in_valid = 1'b1; clk_en = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a_in = TH_P2;  // second request, held through BUSY and HOLD
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_valid, in_ready, res_a, res_b} !== {1'b1, 1'b0, C0_A, C0_B}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%b a=%h b=%h exp v=1 r=0 a=%h b=%h", k, out_valid, in_ready, res_a, res_b, C0_A, C0_B);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_handshake got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_reaccept got in_ready %b exp 0", in_ready); end
        in_valid = 1'b0; a_in = '0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 12) begin errors++; $display("FAIL bp_second_latency got %0d exp 12", lat); end
        checks++; if ({res_a, res_b} !== {CP2_A, CP2_B}) begin errors++; $display("FAIL bp_second_result got %h %h exp %h %h", res_a, res_b, CP2_A, CP2_B); end
        release_result();
    endtask

    task automatic test_clk_en();
        int lat;
        clk_en = 1'b0; mode = 1'b0; a_in = TH_NQ; in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL en_idle_freeze got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        clk_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = '0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_accept got in_ready %b exp 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 200) begin
            clk_en = (lat % 2 == 1);
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 24) begin errors++; $display("FAIL en_latency got %0d exp 24", lat); end
        checks++; if ({res_a, res_b} !== {CQ_A, CQ_B}) begin errors++; $display("FAIL en_result got %h %h exp %h %h", res_a, res_b, CQ_A, CQ_B); end
        clk_en = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL en_hold_freeze got out_valid %b exp 1", out_valid); end
        clk_en = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL en_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        mode = 1'b0; a_in = '0; in_valid = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL rstmid_flags got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        checks++; if (res_a !== '0) begin errors++; $display("FAIL rstmid_res_a got %h exp 0", res_a); end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got %b exp 0", seen); end
    endtask

    task automatic test_reset_hold();
        int lat;
        do_op(1'b0, TH_PI, '0, lat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rsthold_pre got out_valid %b exp 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({in_ready, out_valid, res_b} !== {2'b10, 19'h0}) begin errors++; $display("FAIL rsthold_post got rdy=%b v=%b b=%h exp rdy=1 v=0 b=0", in_ready, out_valid, res_b); end
    endtask

`ifdef CORDIC_VECTOR_EN
    task automatic test_vector();
        int lat;
        int da;
        int db;
        do_op(1'b1, 19'h08000, 19'h08000, lat);
        da = int'($signed(res_a)) - 32'sh12A18; if (da < 0) da = -da;
        db = int'($signed(res_b)) - 32'sh0C910; if (db < 0) db = -db;
        checks++; if (da > 48) begin errors++; $display("FAIL vec_mag got %h exp ~12a18", res_a); end
        checks++; if (db > 48) begin errors++; $display("FAIL vec_ang got %h exp ~0c910", res_b); end
        release_result();
        do_op(1'b1, 19'h78000, 19'h08000, lat);
        db = int'($signed(res_b)) - 32'sh25B2F; if (db < 0) db = -db;
        checks++; if (db > 48) begin errors++; $display("FAIL vec_q2_ang got %h exp ~25b2f", res_b); end
        release_result();
        do_op(1'b1, '0, '0, lat);
        checks++; if ({res_a, res_b} !== 38'h0) begin errors++; $display("FAIL vec_zero got %h %h exp 0 0", res_a, res_b); end
        release_result();
    endtask
`else
    task automatic test_mode_ignored();
        int lat;
        do_op(1'b1, '0, 19'h12345, lat);
        checks++; if ({res_a, res_b} !== {C0_A, C0_B}) begin errors++; $display("FAIL mode_ignored got %h %h exp %h %h", res_a, res_b, C0_A, C0_B); end
        release_result();
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_quadrants();
        test_backpressure();
        test_clk_en();
        test_reset_mid();
        test_reset_hold();
`ifdef CORDIC_VECTOR_EN
        test_vector();
`else
        test_mode_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
